// File: rtl/gray_position_decoder.sv
// Gray-code position decoder: synchronises, debounces and converts an asynchronous Gray input, then tracks binary position.
// Optional feature macro GRAY_DEC_ERR_CNT_EN adds err_cnt, a saturating 8-bit count of step_err pulses.
module gray_position_decoder #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] gray_in,
    input  logic         enable,
    output logic [N-1:0] pos,
    output logic         pos_valid,
    output logic         dir,
    output logic         step_err,
    output logic         locked
`ifdef GRAY_DEC_ERR_CNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic {ACQUIRE = 1'b0, TRACK = 1'b1} state_t;

    logic [N-1:0]  sync_p0;
    logic [N-1:0]  s_q;
    logic [N-1:0]  s_last;
    logic          vld_p0;
    logic          vld_p1;
    logic          vld_p2;
    logic [CW-1:0] cnt;
    state_t        state;
    logic [N-1:0]  b_new;
    logic [N-1:0]  delta;
    logic          stable;
    logic          accept;
    logic          step_up;
    logic          step_dn;

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Synchroniser and stability counter. The vld_pN chain marks when s_last holds a real
    // sample, so the reset contents of the pipeline are never mistaken for a settled code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            s_q     <= '0;
            s_last  <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= gray_in;
            s_q     <= sync_p0;
            s_last  <= s_q;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            if (!vld_p2 || (s_q != s_last)) begin
                cnt <= '0;
            end else if (cnt != CW'(STABLE_CYCLES)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign b_new   = gray2bin(s_last);
    assign delta   = b_new - pos;
    assign stable  = (cnt == CW'(STABLE_CYCLES));
    assign accept  = enable && stable && ((state == ACQUIRE) || (b_new != pos));
    assign step_up = (delta == N'(1));
    assign step_dn = (delta == {N{1'b1}});

    // Tracking FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACQUIRE;
            pos       <= '0;
            dir       <= 1'b0;
            pos_valid <= 1'b0;
            step_err  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            pos_valid <= 1'b0;
            step_err  <= 1'b0;
            if (!enable) begin
                state  <= ACQUIRE;
                locked <= 1'b0;
            end else if (accept) begin
                pos       <= b_new;
                pos_valid <= 1'b1;
                case (state)
                    ACQUIRE: begin
                        state  <= TRACK;
                        locked <= 1'b1;
                    end
                    TRACK: begin
                        if (step_up) begin
                            dir <= 1'b1;
                        end else if (step_dn) begin
                            dir <= 1'b0;
                        end else begin
                            step_err <= 1'b1;
                        end
                    end
                    default: state <= ACQUIRE;
                endcase
            end
        end
    end

`ifdef GRAY_DEC_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (accept && (state == TRACK) && !step_up && !step_dn && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
